// File: rtl/max7219_receiver.sv
// MAX7219-style serial receiver: synchronizes din/cs/sclk, captures 16-bit frames and decodes the register map.
// Optional daisy-chain output enabled by defining MAX7219_RX_DAISY_EN; otherwise dout is tied low.
module max7219_receiver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        cs,
  input  logic        sclk,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] frame_word,
  output logic        dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Bit order within the synchronizer vectors: {cs, sclk, din}; cs idles high.
  localparam logic [2:0] SYNC_RST = 3'b100;

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] hist_q;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] frame_word_q, frame_word_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  digit_q [8];
  logic [7:0]  digit_d [8];
  logic [7:0]  decode_mode_q, decode_mode_d;
  logic [3:0]  intensity_q, intensity_d;
  logic [2:0]  scan_limit_q, scan_limit_d;
  logic        shutdown_n_q, shutdown_n_d;
  logic        display_test_q, display_test_d;

  logic        cs_fall;
  logic        cs_rise;
  logic        sclk_rise;
  logic        din_s;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  digit_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      hist_q  <= SYNC_RST;
    end else begin
      sync1_q <= {cs, sclk, din};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign cs_fall   = hist_q[2] & ~sync2_q[2];
  assign cs_rise   = ~hist_q[2] & sync2_q[2];
  assign sclk_rise = ~hist_q[1] & sync2_q[1];
  // din is taken one cycle before the detected sclk rise for extra setup margin.
  assign din_s     = hist_q[0];

  assign wr_addr   = shift_q[11:8];
  assign wr_data   = shift_q[7:0];
  // Addresses 1..8 map to digits 0..7; the 3-bit wrap turns 8 into 7.
  assign digit_idx = wr_addr[2:0] - 3'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    frame_word_d   = frame_word_q;
    frame_valid_d  = 1'b0;
    frame_err_d    = 1'b0;
    digit_d        = digit_q;
    decode_mode_d  = decode_mode_q;
    intensity_d    = intensity_q;
    scan_limit_d   = scan_limit_q;
    shutdown_n_d   = shutdown_n_q;
    display_test_d = display_test_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = 5'd0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_LATCH;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], din_s};
          if (cnt_q != 5'd16) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
        if (cnt_q == 5'd16) begin
          frame_valid_d = 1'b1;
          frame_word_d  = shift_q;
          case (wr_addr)
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: digit_d[digit_idx] = wr_data;
            4'h9:    decode_mode_d  = wr_data;
            4'hA:    intensity_d    = wr_data[3:0];
            4'hB:    scan_limit_d   = wr_data[2:0];
            4'hC:    shutdown_n_d   = wr_data[0];
            4'hF:    display_test_d = wr_data[0];
            default: ;
          endcase
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 5'd0;
      shift_q        <= 16'h0000;
      frame_word_q   <= 16'h0000;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= 8'h00;
      end
      decode_mode_q  <= 8'h00;
      intensity_q    <= 4'h0;
      scan_limit_q   <= 3'd0;
      shutdown_n_q   <= 1'b0;
      display_test_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      frame_word_q   <= frame_word_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
      digit_q        <= digit_d;
      decode_mode_q  <= decode_mode_d;
      intensity_q    <= intensity_d;
      scan_limit_q   <= scan_limit_d;
      shutdown_n_q   <= shutdown_n_d;
      display_test_q <= display_test_d;
    end
  end

  assign rd_data      = digit_q[rd_addr];
  assign decode_mode  = decode_mode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign shutdown_n   = shutdown_n_q;
  assign display_test = display_test_q;
  assign frame_valid  = frame_valid_q;
  assign frame_err    = frame_err_q;
  assign frame_word   = frame_word_q;

`ifdef MAX7219_RX_DAISY_EN
  logic dout_q, dout_d;
  logic sclk_fall;

  assign sclk_fall = hist_q[1] & ~sync2_q[1];

  always_comb begin
    dout_d = dout_q;
    if (state_q == ST_SHIFT && sclk_fall) begin
      dout_d = shift_q[15];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_receiver.sv
// Scoreboard bench for max7219_receiver: frames are bit-banged at clk/8, expected pulses queued at cs rise.
// Define MAX7219_RX_DAISY_EN for both bench and RTL to exercise the daisy-chain output.
module tb_max7219_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        cs;
  logic        sclk;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;
  logic        frame_valid;
  logic        frame_err;
  logic [15:0] frame_word;
  logic        dout;

  max7219_receiver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .cs           (cs),
    .sclk         (sclk),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err),
    .frame_word   (frame_word),
    .dout         (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_valid;
    logic [15:0] word;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_cnt = 0;
  logic [31:0] daisy_cap;

  logic [7:0]  m_digit [8];
  logic [7:0]  m_decode;
  logic [3:0]  m_int;
  logic [2:0]  m_scan;
  logic        m_shdn;
  logic        m_test;
  logic [15:0] m_word;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
    m_decode = 8'h00;
    m_int    = 4'h0;
    m_scan   = 3'd0;
    m_shdn   = 1'b0;
    m_test   = 1'b0;
    m_word   = 16'h0000;
  endtask

  task automatic model_apply(input logic [15:0] w);
    logic [3:0] a;
    a = w[11:8];
    m_word = w;
    if (a >= 4'h1 && a <= 4'h8) m_digit[a - 4'h1] = w[7:0];
    else if (a == 4'h9) m_decode = w[7:0];
    else if (a == 4'hA) m_int = w[3:0];
    else if (a == 4'hB) m_scan = w[2:0];
    else if (a == 4'hC) m_shdn = w[0];
    else if (a == 4'hF) m_test = w[0];
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".decode_mode"}, decode_mode, m_decode);
    check_eq({tag, ".intensity"}, intensity, m_int);
    check_eq({tag, ".scan_limit"}, scan_limit, m_scan);
    check_eq({tag, ".shutdown_n"}, shutdown_n, m_shdn);
    check_eq({tag, ".display_test"}, display_test, m_test);
    check_eq({tag, ".frame_word"}, frame_word, m_word);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check_eq($sformatf("%s.digit%0d", tag, i), rd_data, m_digit[i]);
    end
  endtask

  // Sends the low n bits of 'bits' MSB first, then queues the expected outcome at the cs rise.
  task automatic send_frame(input logic [31:0] bits, input int n);
    exp_t e;
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0;
      din  = bits[i];
      repeat (4) @(negedge clk);
      daisy_cap = {daisy_cap[30:0], dout};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    e.is_valid = (n >= 16);
    if (e.is_valid) model_apply(bits[15:0]);
    e.word = m_word;
    e.cyc  = cyc_cnt + 4;
    exp_q.push_back(e);
    $display("[TB] frame 0x%0h (%0d bits) sent", bits, n);
    repeat (10) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (frame_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("pulse_valid", frame_valid, e.is_valid);
        check_eq("pulse_err", frame_err, !e.is_valid);
        check_eq("pulse_latency", cyc_cnt, e.cyc);
        check_eq("pulse_word", frame_word, e.word);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cs        = 1'b1;
    sclk      = 1'b0;
    din       = 1'b0;
    rd_addr   = 3'd0;
    daisy_cap = 32'd0;
    model_reset();
    repeat (5) @(negedge clk);
    check_regs("reset");
    check_eq("reset.dout", dout, 1'b0);
    check_eq("reset.frame_valid", frame_valid, 1'b0);
    check_eq("reset.frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(32'h0C01, 16);
    check_regs("shutdown");
    send_frame(32'h0105, 16);
    check_regs("digit0");
    send_frame(32'h0A0F, 16);
    check_regs("intensity");
    send_frame(32'h0D33, 16);
    check_regs("noop_d");
    send_frame(32'h0B07, 12);
    check_regs("short");
    send_frame(32'hF0B07, 20);
    check_regs("long");
    send_frame(32'h0903, 16);
    send_frame(32'hF08AA, 16);
    send_frame(32'h0F01, 16);
    send_frame(32'h0000, 16);
    check_regs("misc");

`ifdef MAX7219_RX_DAISY_EN
    send_frame(32'h0C01_0A05, 32);
    check_regs("daisy");
    check_eq("daisy.stream", daisy_cap[15:0], 16'h0C01);
`else
    check_eq("dout_tied", dout, 1'b0);
`endif

    // Reset in the middle of bit 8 of a frame must abort it silently.
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b0;
      din  = i[0];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    din  = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    cs   = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("[TB] mid-frame reset applied");
    repeat (10) @(negedge clk);
    check_regs("midreset");
    check_eq("midreset.dout", dout, 1'b0);

    send_frame(32'h0A03, 16);
    check_regs("after_reset");

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/max7219_receiver.md
MAX7219_RECEIVER -- requirements
Module: max7219_receiver

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port din  input  1  serial data, asynchronous to clk.
REQ-004 SHALL have port cs  input  1  load/chip-select, active-low, asynchronous to clk.
REQ-005 SHALL have port sclk  input  1  serial clock, asynchronous to clk.
REQ-006 SHALL have port rd_addr  input  3  digit select 0..7 for rd_data.
REQ-007 SHALL have port rd_data  output  8  digit register[rd_addr], combinational read.
REQ-008 SHALL have port decode_mode  output  8  register 0x9.
REQ-009 SHALL have port intensity  output  4  register 0xA bits [3:0].
REQ-010 SHALL have port scan_limit  output  3  register 0xB bits [2:0].
REQ-011 SHALL have port shutdown_n  output  1  register 0xC bit 0 (0 = shutdown).
REQ-012 SHALL have port display_test  output  1  register 0xF bit 0.
REQ-013 SHALL have port frame_valid  output  1  one-cycle pulse per accepted frame.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse per short frame.
REQ-015 SHALL have port frame_word  output  16  last accepted frame {addr[11:8], data[7:0]}, bits [15:12] as received.
REQ-016 SHALL have port dout  output  1  daisy-chain serial output (see Configuration).

Function
REQ-017 din, cs, sclk SHALL each pass a 2-flop synchronizer plus one history flop; edges are detected on synchronized values only.
REQ-018 Correct operation SHALL be guaranteed for clk frequency >= 4x sclk frequency, with sclk high and low phases each >= 2 clk periods.
REQ-019 FSM states: IDLE (cs high), SHIFT (cs low), LATCH (one cycle); IDLE->SHIFT on synchronized cs fall; SHIFT->LATCH on synchronized cs rise; LATCH->IDLE unconditionally.
REQ-020 Entering SHIFT SHALL clear the bit counter; the 16-bit shift register is not cleared.
REQ-021 In SHIFT, each synchronized sclk rising edge SHALL shift din into bit 0 (MSB first) and increment the bit counter, saturating at 16.
REQ-022 An sclk rise detected in the same cycle as the cs rise SHALL be ignored.
REQ-023 Frames with more than 16 bits SHALL use the last 16 bits received.
REQ-024 In LATCH with counter = 16: frame_word <= shift register, frame_valid = 1 for that cycle, register write per REQ-026.
REQ-025 In LATCH with counter < 16: frame_err = 1 for that cycle; no register or frame_word change.
REQ-026 Address = bits [11:8]: 0x0 no-op; 0x1..0x8 digit[addr-1] <= data; 0x9 decode_mode; 0xA intensity <= data[3:0]; 0xB scan_limit <= data[2:0]; 0xC shutdown_n <= data[0]; 0xF display_test <= data[0]; 0xD, 0xE ignored (frame_valid still pulses).
REQ-027 Latency: frame_valid and register updates SHALL appear exactly 4 clk edges after the first edge at which the raw cs high is sampled.
REQ-028 Frame bits [15:12] SHALL be don't-care for decode.

Reset
REQ-029 While rst_n is low at a clk edge: FSM = IDLE, counter = 0, shift register = 0, synchronizer/history flops = 1 for cs and 0 for sclk/din.
REQ-030 Reset outputs: all digit registers 0x00, decode_mode 0x00, intensity 0x0, scan_limit 0, shutdown_n 0, display_test 0, frame_valid 0, frame_err 0, frame_word 0x0000, dout 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame: no frame_valid or frame_err pulse for it.

Configuration
REQ-032 Macro MAX7219_RX_DAISY_EN defined: dout SHALL present shift-register bit 15, updated on each synchronized sclk falling edge while in SHIFT, held otherwise; 16 bits later it reproduces the input stream.
REQ-033 Macro MAX7219_RX_DAISY_EN undefined: dout SHALL be constant 0 and no extra flops are inferred.

Verification
REQ-034 Frame 0x0C01 at clk/8 -> frame_valid one pulse, shutdown_n = 1, frame_word = 0x0C01.
REQ-035 Frame 0x0105 then rd_addr = 0 -> rd_data = 0x05; rd_addr = 1 -> 0x00.
REQ-036 Frame 0x0A0F -> intensity = 0xF; then frame 0x0D33 -> frame_valid pulse, no register change.
REQ-037 12-bit frame 0xB07 then cs high -> frame_err one pulse, frame_valid 0, all registers unchanged.
REQ-038 20-bit stream 0xF0B07 -> scan_limit = 7 (last 16 bits 0x0B07 used); rst_n low during bit 8 of a following frame -> no pulse, all outputs at reset values.
REQ-039 With MAX7219_RX_DAISY_EN: 32-bit frame 0x0C01_0A05 -> dout bit stream over the second 16 sclk periods equals 0x0C01; intensity = 5.
